mmio_port_bridge: RTL and testbench

- Memory-mapped I/O bridge that sits directly downstream of the pipeline's MEM stage, in parallel with DataMemory.
- Decodes the EX/MEM ALU result address and services stores and loads to a small I/O window.
- Drives the processor's PortOut register and synchronizes PortIn.
- Buffers byte writes in a TX FIFO with a valid/ready handshake toward an external consumer, such as a future UART.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_port_bridge.sv | 145 ++++++++++++++
 tb/tb_mmio_port_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port bridge: register offsets, STATUS bit
// positions and the default window base address.
package mmio_pkg;

    typedef logic [1:0] io_off_t;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'hFFFF_0000;

    // Word offsets inside the 16-byte window (Address[3:2])
    localparam io_off_t OFF_PORT_OUT = 2'd0;
    localparam io_off_t OFF_PORT_IN  = 2'd1;
    localparam io_off_t OFF_TX_DATA  = 2'd2;
    localparam io_off_t OFF_STATUS   = 2'd3;

    // STATUS register bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_IN_CHG  = 8;
    localparam int ST_OVF     = 9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO. The head entry is presented from the
// storage registers, so it stays put until popped. A push into a full FIFO
// is only taken when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CW    = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/mmio_port_bridge.sv
// MMIO bridge beside DataMemory: decodes a 16-byte I/O window, holds the
// PortOut register, synchronizes PortIn, and queues TX bytes for an external
// valid/ready consumer.
module mmio_port_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = DEFAULT_IO_BASE,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        IOSelect,
    output logic [31:0] ReadData,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady
);

    logic             w_sel;
    io_off_t          w_off;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_unused_addr;
    logic             w_push_req;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_ovf_set;
    logic             w_chg_set;
    logic             w_status_wr;
    logic [31:0]      w_status;

    logic [31:0]      r_port_out;
    logic [7:0]       r_pin_s1;
    logic [7:0]       r_pin_sync;
    logic [7:0]       r_pin_prev;
    logic             r_in_chg;
    logic             r_ovf;

    // Window decode; byte lane bits are don't-care for word registers
    assign w_sel         = (Address[31:4] == IO_BASE[31:4]);
    assign w_off         = Address[3:2];
    assign w_unused_addr = ^Address[1:0];
    assign w_wr_en       = MemWrite & w_sel;
    assign w_rd_en       = MemRead & w_sel;
    assign IOSelect      = w_sel;

    assign w_push_req  = w_wr_en & (w_off == OFF_TX_DATA);
    assign w_status_wr = w_wr_en & (w_off == OFF_STATUS);
    assign w_pop       = TxValid & TxReady;
    assign w_ovf_set   = w_push_req & w_full & ~w_pop;
    assign w_chg_set   = (r_pin_sync != r_pin_prev);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_req),
        .din   (WriteData[7:0]),
        .pop   (w_pop),
        .dout  (TxData),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign TxValid = ~w_empty;

    // PortOut register, written by stores to PORT_OUT
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_port_out <= '0;
        end else if (w_wr_en && (w_off == OFF_PORT_OUT)) begin
            r_port_out <= WriteData;
        end
    end

    assign PortOut = r_port_out;

    // Two-flop PortIn synchronizer plus a history flop for change detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pin_s1   <= '0;
            r_pin_sync <= '0;
            r_pin_prev <= '0;
        end else begin
            r_pin_s1   <= PortIn;
            r_pin_sync <= r_pin_s1;
            r_pin_prev <= r_pin_sync;
        end
    end

    // Sticky flags: a new event wins over a same-cycle write-1-to-clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_chg <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_chg_set)
                r_in_chg <= 1'b1;
            else if (w_status_wr && WriteData[ST_IN_CHG])
                r_in_chg <= 1'b0;

            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_status_wr && WriteData[ST_OVF])
                r_ovf <= 1'b0;
        end
    end

    // STATUS word assembly
    always_comb begin
        w_status                          = '0;
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
        w_status[ST_CNT_LSB +: CNT_W]     = w_count;
        w_status[ST_IN_CHG]               = r_in_chg;
        w_status[ST_OVF]                  = r_ovf;
    end

    // Combinational read mux, same-cycle like DataMemory; zero when not selected
    always_comb begin
        ReadData = '0;
        if (w_rd_en) begin
            case (w_off)
                OFF_PORT_OUT: ReadData = r_port_out;
                OFF_PORT_IN:  ReadData = {24'b0, r_pin_sync};
                OFF_TX_DATA:  ReadData = '0;
                OFF_STATUS:   ReadData = w_status;
                default:      ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Testbench for mmio_port_bridge: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_mmio_port_bridge;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        IOSelect;
    logic [31:0] ReadData;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_port;
    logic [7:0]  m_q[$];
    logic [7:0]  m_h1, m_h2, m_h3;   // PortIn sampled 1, 2, 3 edges ago
    logic        m_chg;
    logic        m_ovf;

    logic [7:0]  exp_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  exp_b [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

    mmio_port_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .IOSelect  (IOSelect),
        .ReadData  (ReadData),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic logic [31:0] m_status();
        int n;
        n = m_q.size();
        return 32'((n == DEPTH) ? 1 : 0) + 32'((n == 0) ? 2 : 0) + 32'(4 * n)
             + (m_chg ? 32'd256 : 32'd0) + (m_ovf ? 32'd512 : 32'd0);
    endfunction

    function automatic logic [31:0] m_read(input bit mr, input logic [31:0] a);
        logic [31:0] rel;
        if (!(mr && m_in_window(a))) return 32'd0;
        rel = (a - BASE) / 4;
        case (rel)
            32'd0:   return m_port;
            32'd1:   return {24'd0, m_h2};
            32'd3:   return m_status();
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_port = '0;
        m_q.delete();
        m_h1 = '0; m_h2 = '0; m_h3 = '0;
        m_chg = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One clock: drive, check outputs mid-cycle, then advance the model across the edge
    task automatic step(input bit rst_n, input bit mw, input bit mr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [7:0] pin, input bit rdy);
        bit          wr, pop, chg_evt, ovf_evt;
        logic [31:0] rel;
        reset = rst_n; MemWrite = mw; MemRead = mr; Address = a;
        WriteData = wd; PortIn = pin; TxReady = rdy;
        #1;
        chk("iosel",   32'(IOSelect), 32'(m_in_window(a)));
        chk("rdata",   ReadData, m_read(mr, a));
        chk("portout", PortOut, m_port);
        chk("txvalid", 32'(TxValid), 32'(m_q.size() != 0));
        chk("txdata",  32'(TxData), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            wr      = mw && m_in_window(a);
            rel     = (a - BASE) / 4;
            pop     = (m_q.size() != 0) && rdy;
            chg_evt = (m_h2 != m_h3);
            ovf_evt = 1'b0;
            if (wr && rel == 0) m_port = wd;
            if (pop) void'(m_q.pop_front());
            if (wr && rel == 2) begin
                if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]);
                else ovf_evt = 1'b1;
            end
            if (ovf_evt) m_ovf = 1'b1;
            else if (wr && rel == 3 && wd[9]) m_ovf = 1'b0;
            if (chg_evt) m_chg = 1'b1;
            else if (wr && rel == 3 && wd[8]) m_chg = 1'b0;
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = pin;
        end
        @(negedge clk);
    endtask

    task automatic peek(input logic [31:0] a);
        MemWrite = 1'b0; MemRead = 1'b1; Address = a;
        #1;
    endtask

    initial begin
        reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Address = '0;
        WriteData = '0; PortIn = '0; TxReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();

        // Reset state
        chk("rst_portout", PortOut, 32'd0);
        chk("rst_txvalid", 32'(TxValid), 32'd0);
        chk("rst_txdata",  32'(TxData), 32'd0);
        peek(BASE + 32'hC);
        chk("rst_status",  ReadData, 32'h0000_0002);

        // PortOut write, read-back, reset
        step(1, 1, 0, BASE, 32'hDEAD_BEEF, 8'h00, 0);
        chk("portout_wr", PortOut, 32'hDEAD_BEEF);
        peek(BASE);
        chk("portout_rd", ReadData, 32'hDEAD_BEEF);
        chk("portout_sel", 32'(IOSelect), 32'd1);
        step(0, 0, 0, BASE, 32'd0, 8'h00, 0);
        chk("portout_rst", PortOut, 32'd0);

        // PortIn synchronization and in_changed
        step(1, 0, 1, BASE + 4, 32'd0, 8'hA5, 0);
        peek(BASE + 4);
        chk("pin_edge1", ReadData, 32'h0000_0000);
        step(1, 0, 1, BASE + 4, 32'd0, 8'hA5, 0);
        peek(BASE + 4);
        chk("pin_edge2", ReadData, 32'h0000_00A5);
        step(1, 0, 1, BASE + 12, 32'd0, 8'hA5, 0);
        peek(BASE + 12);
        chk("inchg_set", 32'(ReadData[8]), 32'd1);
        step(1, 1, 0, BASE + 12, 32'h0000_0100, 8'hA5, 0);
        peek(BASE + 12);
        chk("inchg_clr", 32'(ReadData[8]), 32'd0);

        // Fill past full with consumer stalled
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, BASE + 8, 32'h11 * (i + 1), 8'hA5, 0);
        peek(BASE + 12);
        chk("full_status", ReadData, 32'h0000_0211);
        chk("full_head", 32'(TxData), 32'h11);
        step(1, 0, 0, 32'd0, 32'd0, 8'hA5, 0);
        step(1, 0, 0, 32'd0, 32'd0, 8'hA5, 0);
        chk("head_hold", 32'(TxData), 32'h11);

        // Drain
        for (int i = 0; i < 4; i++) begin
            chk("drain_a", 32'(TxData), 32'(exp_a[i]));
            step(1, 0, 0, 32'd0, 32'd0, 8'hA5, 1);
        end
        chk("drain_a_done", 32'(TxValid), 32'd0);
        peek(BASE + 12);
        chk("drain_a_empty", 32'(ReadData[1]), 32'd1);

        // Full FIFO with simultaneous pop and push, across pointer wrap
        step(1, 1, 0, BASE + 12, 32'h0000_0200, 8'hA5, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, BASE + 8, 32'(exp_a[i]), 8'hA5, 0);
        step(1, 1, 0, BASE + 8, 32'h66, 8'hA5, 1);
        peek(BASE + 12);
        chk("pushpop_cnt", 32'(ReadData[4:2]), 32'd4);
        chk("pushpop_ovf", 32'(ReadData[9]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_b", 32'(TxData), 32'(exp_b[i]));
            step(1, 0, 0, 32'd0, 32'd0, 8'hA5, 1);
        end
        chk("drain_b_done", 32'(TxValid), 32'd0);

        // Out-of-window accesses
        step(1, 1, 0, BASE + 32'h20, 32'h1234_5678, 8'hA5, 0);
        step(1, 1, 0, BASE - 4, 32'h8765_4321, 8'hA5, 0);
        step(1, 1, 0, BASE + 32'h28, 32'h0000_0077, 8'hA5, 0);
        peek(BASE + 32'h20);
        chk("oow_sel", 32'(IOSelect), 32'd0);
        chk("oow_rdata", ReadData, 32'd0);
        chk("oow_portout", PortOut, 32'd0);
        chk("oow_txvalid", 32'(TxValid), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [7:0]  pin;
            int          sel, off;
            sel = int'($urandom_range(0, 9));
            off = int'($urandom_range(0, 5));
            if (off > 3) off = 2;
            if (sel < 8)       a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            else if (sel == 8) a = BASE + 32'd16 + 32'($urandom_range(0, 255));
            else               a = $urandom;
            pin = ($urandom_range(0, 7) == 0) ? 8'($urandom) : PortIn;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, a, $urandom, pin,
                 $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
